topk_stream_sorter: RTL and testbench



---
 rtl/topk_stream_sorter.sv | 159 +++++++++++++++
 tb/tb_topk_stream_sorter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/topk_stream_sorter.sv
// topk_stream_sorter
//   Insertion sorter that keeps the best DEPTH entries of an unbounded
//   valid/ready stream. The stream direction is min or max, chosen per stream.
//   When the last beat is accepted, the stored entries drain in sorted order.
//   Equal keys keep their arrival order.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   mode_max                 0 keeps the smallest keys, 1 the largest;
//                            latched on the first beat of a stream
//   in_key/in_payload        input entry
//   in_last                  final beat of the stream
//   in_vld/in_rdy            input handshake
//   out_key/out_payload      head entry while draining
//   out_last                 head is the final stored entry
//   out_vld/out_rdy          output handshake
//   count                    number of stored entries
//   drop_cnt                 entries discarded or evicted this stream (saturating)
module topk_stream_sorter #(
  parameter int KEY_W = 17,
  parameter int PAY_W = 20,
  parameter int DEPTH = 1000,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_max,
  input  logic [KEY_W-1:0] in_key,
  input  logic [PAY_W-1:0] in_payload,
  input  logic             in_last,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [KEY_W-1:0] out_key,
  output logic [PAY_W-1:0] out_payload,
  output logic             out_last,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [CNT_W-1:0] count,
  output logic [15:0]      drop_cnt
);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t           state_q, state_d;
  logic             run_q;
  logic             fresh_q;
  logic             mode_q;
  logic [CNT_W-1:0] count_q;
  logic [15:0]      drop_q;

  logic [KEY_W-1:0] key_mem [DEPTH];
  logic [PAY_W-1:0] pay_mem [DEPTH];
  logic [KEY_W-1:0] key_nxt [DEPTH];
  logic [PAY_W-1:0] pay_nxt [DEPTH];

  logic [DEPTH-1:0] keep;
  logic             accept;
  logic             handshake;
  logic             full;
  logic             do_ins;

  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    case (state_q)
      FILL: begin
        in_rdy = run_q;
        if (in_vld && run_q && in_last) state_d = DRAIN;
      end
      DRAIN: begin
        out_vld = 1'b1;
        if (out_rdy && (count_q == CNT_W'(1))) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  assign accept      = in_vld && in_rdy;
  assign handshake   = out_vld && out_rdy;
  assign full        = (count_q == CNT_W'(DEPTH));
  assign out_last    = out_vld && (count_q == CNT_W'(1));
  assign out_key     = key_mem[0];
  assign out_payload = pay_mem[0];
  assign count       = count_q;
  assign drop_cnt    = drop_q;

  // Occupied slots whose key is not beaten by the new key form a prefix of
  // the sorted array. Equal keys stay in place, which keeps tie order stable.
  always_comb begin
    keep = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      keep[i] = (CNT_W'(i) < count_q) &&
                !(mode_q ? (in_key > key_mem[i]) : (in_key < key_mem[i]));
    end
  end

  // When full, an entry that does not beat the last slot leaves keep[] all
  // ones. In that case the entry is discarded. Otherwise the last slot falls
  // off the end.
  assign do_ins = accept && (!full || !keep[DEPTH-1]);

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      key_nxt[i] = key_mem[i];
      pay_nxt[i] = pay_mem[i];
      if (do_ins && !keep[i]) begin
        if (i == 0 || keep[(i == 0) ? 0 : i - 1]) begin
          key_nxt[i] = in_key;
          pay_nxt[i] = in_payload;
        end else begin
          key_nxt[i] = key_mem[(i == 0) ? 0 : i - 1];
          pay_nxt[i] = pay_mem[(i == 0) ? 0 : i - 1];
        end
      end else if (handshake) begin
        key_nxt[i] = key_mem[(i == DEPTH - 1) ? i : i + 1];
        pay_nxt[i] = pay_mem[(i == DEPTH - 1) ? i : i + 1];
      end
    end
  end

  always_ff @(posedge clk) begin
    key_mem <= key_nxt;
    pay_mem <= pay_nxt;
  end

  // Stream start is tracked with its own flag. A count/drop test cannot be
  // used, because drop_cnt must hold its value until the next stream begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      run_q   <= 1'b0;
      fresh_q <= 1'b1;
      mode_q  <= 1'b0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (accept) begin
        if (fresh_q) begin
          mode_q  <= mode_max;
          fresh_q <= 1'b0;
          drop_q  <= '0;
        end
        if (!full) begin
          count_q <= count_q + CNT_W'(1);
        end else if (drop_q != '1) begin
          drop_q <= drop_q + 16'd1;
        end
      end
      if (handshake) begin
        count_q <= count_q - CNT_W'(1);
        if (out_last) fresh_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_topk_stream_sorter.sv
module tb_topk_stream_sorter;

  localparam int KW = 17;
  localparam int PW = 20;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          mode_max;
  logic [KW-1:0] in_key;
  logic [PW-1:0] in_payload;
  logic          in_last;
  logic          in_vld;
  logic          in_rdy;
  logic [KW-1:0] out_key;
  logic [PW-1:0] out_payload;
  logic          out_last;
  logic          out_vld;
  logic          out_rdy;
  logic [CW-1:0] count;
  logic [15:0]   drop_cnt;

  topk_stream_sorter #(.KEY_W(KW), .PAY_W(PW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .mode_max(mode_max),
    .in_key(in_key), .in_payload(in_payload), .in_last(in_last),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .out_key(out_key), .out_payload(out_payload), .out_last(out_last),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: sorted queue, best first, bounded at D entries.
  typedef struct { logic [KW-1:0] k; logic [PW-1:0] p; } ent_t;
  ent_t m_q[$];
  int   m_drop  = 0;
  bit   m_mode  = 1'b0;
  bit   m_fresh = 1'b1;

  function automatic bit better(logic [KW-1:0] a, logic [KW-1:0] b);
    return m_mode ? (a > b) : (a < b);
  endfunction

  task automatic model_accept(logic [KW-1:0] k, logic [PW-1:0] p, bit md);
    ent_t e;
    int   idx;
    if (m_fresh) begin
      m_mode  = md;
      m_drop  = 0;
      m_fresh = 1'b0;
    end
    e.k = k;
    e.p = p;
    idx = m_q.size();
    for (int i = 0; i < m_q.size(); i++) begin
      if (better(k, m_q[i].k)) begin
        idx = i;
        break;
      end
    end
    if (idx >= D) begin
      if (m_drop < 65535) m_drop++;
    end else begin
      m_q.insert(idx, e);
      if (m_q.size() > D) begin
        void'(m_q.pop_back());
        if (m_drop < 65535) m_drop++;
      end
    end
  endtask

  task automatic send_beat(logic [KW-1:0] k, logic [PW-1:0] p, bit last);
    int n = 0;
    bit md;
    in_key = k; in_payload = p; in_last = last; in_vld = 1'b1;
    while (!in_rdy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_rdy) begin
      chk("in_rdy_timeout", in_rdy, 1);
      in_vld = 1'b0;
      return;
    end
    md = mode_max;
    @(posedge clk); #1;
    model_accept(k, p, md);
    in_vld = 1'b0; in_last = 1'b0;
    chk("count", count, m_q.size());
    chk("drop_cnt", drop_cnt, m_drop);
    if (last) begin
      chk("out_vld_latency", out_vld, 1);
      chk("in_rdy_low_drain", in_rdy, 0);
    end
  endtask

  // rmode: 0 always ready, 1 ready pattern 1,0,0,..., 2 random ready.
  // junk: hold in_vld high with key 0 while draining.
  task automatic drain(int rmode, bit junk, output int hs);
    int cyc = 0;
    int ph  = 0;
    bit v;
    hs = 0;
    while (m_q.size() > 0 && cyc < 400) begin
      in_vld = junk && (m_q.size() > 1);
      in_key = '0; in_payload = '0; in_last = 1'b0;
      case (rmode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = (ph % 3 == 0);
        default: out_rdy = 1'($urandom_range(0, 1));
      endcase
      ph++;
      chk("out_vld", out_vld, 1);
      chk("out_key", out_key, m_q[0].k);
      chk("out_payload", out_payload, m_q[0].p);
      chk("out_last", out_last, (m_q.size() == 1));
      chk("count_drain", count, m_q.size());
      chk("in_rdy_drain", in_rdy, 0);
      v = out_vld;
      @(posedge clk); #1;
      cyc++;
      if (v && out_rdy) begin
        void'(m_q.pop_front());
        hs++;
        if (m_q.size() == 0) m_fresh = 1'b1;
      end
    end
    if (m_q.size() > 0) chk("drain_timeout", out_vld, 0);
    out_rdy = 1'b0; in_vld = 1'b0;
    chk("in_rdy_after_drain", in_rdy, 1);
    chk("out_vld_after_drain", out_vld, 0);
    chk("count_after_drain", count, 0);
    chk("drop_after_drain", drop_cnt, m_drop);
  endtask

  typedef struct {
    bit         mode;
    int         rmode;
    logic [67:0] ek;
    logic [79:0] ep;
    int         edrop;
  } tcase_t;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0", 1);
    $fatal(1);
  end

  initial begin
    tcase_t        tc[3];
    logic [KW-1:0] skeys[6];
    int            hs;
    int            len;

    skeys[0] = 9; skeys[1] = 3; skeys[2] = 7; skeys[3] = 3; skeys[4] = 1; skeys[5] = 8;
    tc[0].mode = 1'b0; tc[0].rmode = 0; tc[0].edrop = 2;
    tc[0].ek = {17'd7, 17'd3, 17'd3, 17'd1};
    tc[0].ep = {20'd2, 20'd3, 20'd1, 20'd4};
    tc[1].mode = 1'b1; tc[1].rmode = 0; tc[1].edrop = 2;
    tc[1].ek = {17'd3, 17'd7, 17'd8, 17'd9};
    tc[1].ep = {20'd1, 20'd2, 20'd5, 20'd0};
    tc[2] = tc[0];
    tc[2].rmode = 1;

    rst = 1'b1; mode_max = 1'b0; in_key = '0; in_payload = '0;
    in_last = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_drop", drop_cnt, 0);
    #10 rst = 1'b0;
    #1 chk("in_rdy_before_edge", in_rdy, 0);
    @(posedge clk); #1;
    chk("in_rdy_after_release", in_rdy, 1);

    // Table-driven directed streams.
    for (int t = 0; t < 3; t++) begin
      mode_max = tc[t].mode;
      for (int b = 0; b < 6; b++) send_beat(skeys[b], PW'(b), b == 5);
      chk("table_drop", drop_cnt, tc[t].edrop);
      m_q.delete();
      for (int i = 0; i < 4; i++) begin
        ent_t e;
        e.k = tc[t].ek[i*KW +: KW];
        e.p = tc[t].ep[i*PW +: PW];
        m_q.push_back(e);
      end
      m_drop = tc[t].edrop;
      drain(tc[t].rmode, 1'b0, hs);
      chk("table_handshakes", hs, 4);
    end

    // Single beat, then a stream in the opposite mode.
    mode_max = 1'b0;
    send_beat(17'd5, 20'd11, 1'b1);
    chk("single_out_last", out_last, 1);
    chk("single_out_key", out_key, 5);
    drain(0, 1'b0, hs);
    mode_max = 1'b1;
    send_beat(17'd2, 20'd1, 1'b0);
    mode_max = 1'b0;
    send_beat(17'd6, 20'd2, 1'b0);
    send_beat(17'd4, 20'd3, 1'b1);
    chk("mode_latched_head", out_key, 6);
    drain(0, 1'b0, hs);

    // Reset during the second drain handshake.
    send_beat(17'd4, 20'd7, 1'b0);
    send_beat(17'd2, 20'd8, 1'b0);
    send_beat(17'd6, 20'd9, 1'b1);
    out_rdy = 1'b1;
    @(posedge clk); #1;
    void'(m_q.pop_front());
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_vld", out_vld, 0);
    chk("midrst_count", count, 0);
    chk("midrst_in_rdy", in_rdy, 0);
    chk("midrst_out_last", out_last, 0);
    m_q.delete(); m_drop = 0; m_fresh = 1'b1;
    out_rdy = 1'b0;
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_in_rdy", in_rdy, 1);
    send_beat(17'd30, 20'd1, 1'b0);
    send_beat(17'd10, 20'd2, 1'b1);
    drain(0, 1'b0, hs);

    // Input held valid during drain must be ignored.
    mode_max = 1'b0;
    send_beat(17'd5, 20'd1, 1'b0);
    send_beat(17'd6, 20'd2, 1'b0);
    send_beat(17'd7, 20'd3, 1'b1);
    drain(0, 1'b1, hs);
    chk("junk_handshakes", hs, 3);

    // Randomized streams against the model.
    for (int s = 0; s < 25; s++) begin
      mode_max = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int b = 0; b < len; b++) begin
        send_beat(KW'($urandom_range(0, 7)), PW'($urandom), b == len - 1);
        mode_max = 1'($urandom_range(0, 1));
      end
      drain(2, 1'($urandom_range(0, 1)), hs);
    end

    // Saturation of drop_cnt.
    mode_max = 1'b0;
    for (int b = 0; b < 65600; b++) begin
      send_beat(KW'($urandom_range(0, 1000)), PW'(b), b == 65599);
    end
    chk("drop_saturated", drop_cnt, 16'hFFFF);
    drain(0, 1'b0, hs);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
